extend_pipe: RTL
================

// Module: extend_pipe
// PURPOSE
//   Registered, parametrised successor of the ID-stage immediate extender.
//   Sits between the decoder and the ID/EX register.
//   Accepts an immediate plus an extend opcode over a valid/ready handshake.
//   Emits the extended word one cycle later and holds it under back-pressure.
//   Supports zero, sign, upper-load and branch-offset (sign, <<2) modes, and a synchronous pipeline flush.
// PARAMETERS
//   IN_W    16  immediate width; legal range 2..OUT_W-2
//   OUT_W   32  extended result width
//   MODE_W  2   ext_op width; only codes 0..3 are decoded
// PORTS
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous, active-low reset
//   flush      in   1       synchronous pipeline flush (branch/exception)
//   in_valid   in   1       ext_op and data are valid
//   in_ready   out  1       block can accept the input this cycle
//   ext_op     in   MODE_W  0=ZERO, 1=SIGN, 2=UPPER, 3=BRANCH
//   data       in   IN_W    raw immediate
//   out_valid  out  1       ext_data is valid
//   out_ready  in   1       consumer takes ext_data this cycle
//   ext_data   out  OUT_W   extended result
//   op_err     out  1       ext_op > 3 on the accepted beat (only when MODE_W>2); registered alongside ext_data
// BEHAVIOUR
// - Reset (rst_n=0, async): out_valid=0, ext_data=0, op_err=0, skid empty, in_ready=1 from the first edge after release.
// - Arithmetic, computed combinationally from the accepted beat:
//     ZERO   = {(OUT_W-IN_W){0}, data}
//     SIGN   = {(OUT_W-IN_W){data[IN_W-1]}, data}
//     UPPER  = data << (OUT_W-IN_W); low bits are 0; no sign usage
//     BRANCH = SIGN << 2, truncated to OUT_W; top 2 sign bits are dropped
//     code >3: result = SIGN, op_err=1
// - Accept: in_valid && in_ready at a rising edge. Latency is 1 cycle from accept to out_valid=1.
// - Output slot:
//     - Loads when it is empty, or when out_valid && out_ready.
//     - Otherwise it holds ext_data and op_err stable, with out_valid=1.
// - Back-to-back: with out_ready held at 1, one beat per cycle; no bubbles.
// - flush=1 at an edge:
//     - out_valid goes to 0 and the skid is emptied.
//     - A beat offered in the same cycle is dropped, even if in_ready=1.
//     - ext_data keeps its last value (don't-care).
//     - Flush takes priority over every other event.
// - rst_n asserted mid-transfer discards all held beats immediately.
// - out_ready is ignored while out_valid=0.
// CONFIGURATION
//   EXTEND_SKID_EN defined:
//     - One-entry skid buffer; in_ready is a pure register output (= skid empty).
//     - A beat accepted while the output is stalled goes to the skid.
//     - The skid moves to the output on the first out_valid && out_ready; in_ready rises on the next edge.
//     - Maximum occupancy is 2 beats; throughput is 1 beat per cycle.
//   EXTEND_SKID_EN undefined:
//     - No skid buffer; in_ready = !out_valid || out_ready (combinational path from out_ready).
//     - Maximum occupancy is 1 beat.
// TESTING
// 1. Reset, then offer op=SIGN, data=16'h8001 with out_ready=1
//    -> next cycle out_valid=1, ext_data=32'hFFFF8001.
// 2. Offer op=ZERO 16'h8001, op=UPPER 16'h1234, op=BRANCH 16'hFFFF on consecutive cycles
//    -> 32'h00008001, 32'h12340000, 32'hFFFFFFFC on consecutive cycles.
// 3. Hold out_ready=0, stream 3 beats (A,B,C)
//    -> SKID_EN: A held at output, B in skid, in_ready=0, C waits; release gives A,B,C in order.
//    -> Without SKID_EN: in_ready=0 after A.
// 4. Output full and in_valid=1, then assert flush for 1 cycle
//    -> out_valid=0 next cycle, offered beat is not emitted, in_ready=1.
// 5. Drop rst_n asynchronously between edges while out_valid=1
//    -> out_valid=0 and ext_data=0 immediately, without waiting for an edge.
// 6. Instance with IN_W=12, OUT_W=32, MODE_W=3, op=5, data=12'h800
//    -> ext_data=32'hFFFFF800, op_err=1.

Source files
------------

// File: rtl/extend_pipe.sv
// extend_pipe: registered immediate extender (zero/sign/upper/branch) with valid/ready, flush and optional skid buffer (EXTEND_SKID_EN)
module extend_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int MODE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MODE_W-1:0] ext_op,
    input  logic [IN_W-1:0]   data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  ext_data,
    output logic              op_err
);
    logic [OUT_W-1:0] zext, sext, res;
    logic             err, out_free, accept;
    always_comb begin
        zext = {{(OUT_W-IN_W){1'b0}}, data};
        sext = {{(OUT_W-IN_W){data[IN_W-1]}}, data};
        err  = 32'(ext_op) > 32'd3;
        res  = ext_op == MODE_W'(0) ? zext :
               ext_op == MODE_W'(2) ? zext << (OUT_W-IN_W) :
               ext_op == MODE_W'(3) ? sext << 2 : sext;
    end
    assign out_free = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
`ifdef EXTEND_SKID_EN
    logic             skid_valid, skid_err;
    logic [OUT_W-1:0] skid_data;
    assign in_ready = !skid_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            ext_data   <= '0;
            op_err     <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            out_valid <= skid_valid || accept;
            if (skid_valid) begin
                ext_data   <= skid_data;
                op_err     <= skid_err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                ext_data <= res;
                op_err   <= err;
            end
        end else if (accept) begin
            skid_data  <= res;
            skid_err   <= err;
            skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = out_free;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ext_data  <= '0;
            op_err    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (out_free) begin
            out_valid <= accept;
            if (accept) begin
                ext_data <= res;
                op_err   <= err;
            end
        end
    end
`endif
endmodule
